// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and widths for the unified memory port arbiter
//   resp_sel_t : which port owns the response in flight (none / fetch / data)
//   DW, BEW    : data width and byte-enable width
package mem_arb_pkg;
    localparam int DW  = 32;
    localparam int BEW = 4;
    typedef enum logic [1:0] {RESP_NONE, RESP_I, RESP_D} resp_sel_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch port, data port, RAM port and stall lines of the arbiter
//   master : pipeline/RAM side (drives requests and ram_rdata)
//   slave  : arbiter side (drives grants, responses, RAM controls, stalls)
//   MEM_ARB_PERF_EN adds perf_conflict/perf_starve to both modports
interface mem_port_arbiter_if #(parameter int AW = 8);
    import mem_arb_pkg::*;
    logic           i_req, i_gnt, i_rvalid;
    logic [31:0]    i_addr;
    logic [DW-1:0]  i_rdata;
    logic           d_req, d_gnt, d_rvalid;
    logic [BEW-1:0] d_we;
    logic [31:0]    d_addr;
    logic [DW-1:0]  d_wdata, d_rdata;
    logic           ram_en;
    logic [BEW-1:0] ram_we;
    logic [AW-1:0]  ram_addr;
    logic [DW-1:0]  ram_wdata, ram_rdata;
    logic           stall_i, stall_d;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]    perf_conflict, perf_starve;
    modport master (output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
                    input i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
                    ram_en, ram_we, ram_addr, ram_wdata, stall_i, stall_d,
                    perf_conflict, perf_starve);
    modport slave  (input i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
                    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
                    ram_en, ram_we, ram_addr, ram_wdata, stall_i, stall_d,
                    perf_conflict, perf_starve);
`else
    modport master (output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
                    input i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
                    ram_en, ram_we, ram_addr, ram_wdata, stall_i, stall_d);
    modport slave  (input i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
                    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
                    ram_en, ram_we, ram_addr, ram_wdata, stall_i, stall_d);
`endif
endinterface

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: saturating count of consecutive fetch denials
//   clk, rst (sync, active-low), inc, clr in; at_max out when count == STARVE_MAX
module mem_arb_starve_ctr #(parameter int STARVE_MAX = 4) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk)
        if (!rst || clr) cnt <= '0;
        else if (inc && !at_max) cnt <= cnt + 1'b1;
    assign at_max = cnt == CW'(STARVE_MAX);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 1-cycle-latency RAM between fetch and data ports
//   clk, rst (sync, active-low) plain ports; bus (slave modport) carries the
//   fetch/data request-grant-response signals, RAM controls and stall_i/stall_d.
//   Data beats fetch on conflict unless fetch has been denied STARVE_MAX times.
//   Define MEM_ARB_PERF_EN for perf_conflict/perf_starve counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    logic      at_max, i_gnt, d_gnt, resp_wr, wr_nxt;
    resp_sel_t resp_sel, resp_nxt;
    assign i_gnt = rst && bus.i_req && (!bus.d_req || at_max);
    assign d_gnt = rst && bus.d_req && !(bus.i_req && at_max);
    assign bus.i_gnt     = i_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.stall_i   = bus.i_req && !i_gnt;
    assign bus.stall_d   = bus.d_req && !d_gnt;
    assign bus.ram_en    = i_gnt || d_gnt;
    assign bus.ram_we    = d_gnt ? bus.d_we : '0;
    assign bus.ram_wdata = d_gnt ? bus.d_wdata : '0;
    assign bus.ram_addr  = d_gnt ? bus.d_addr[AW+1:2] : i_gnt ? bus.i_addr[AW+1:2] : '0;
    mem_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (bus.i_req && bus.d_req && d_gnt),
        .clr    (i_gnt || !bus.i_req),
        .at_max (at_max)
    );
    always_ff @(posedge clk)
        if (!rst) begin
            resp_sel <= RESP_NONE;
            resp_wr  <= 1'b0;
        end else begin
            resp_sel <= resp_nxt;
            resp_wr  <= wr_nxt;
        end
    always_comb begin
        resp_nxt = d_gnt ? RESP_D : i_gnt ? RESP_I : RESP_NONE;
        wr_nxt   = d_gnt && |bus.d_we;
    end
    // stores complete with a valid beat but never expose RAM read data
    assign bus.i_rvalid = resp_sel == RESP_I;
    assign bus.d_rvalid = resp_sel == RESP_D;
    assign bus.i_rdata  = bus.i_rvalid ? bus.ram_rdata : '0;
    assign bus.d_rdata  = (bus.d_rvalid && !resp_wr) ? bus.ram_rdata : '0;
`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk)
        if (!rst) begin
            bus.perf_conflict <= '0;
            bus.perf_starve   <= '0;
        end else begin
            if (bus.i_req && bus.d_req) bus.perf_conflict <= bus.perf_conflict + 32'd1;
            if (i_gnt && bus.d_req) bus.perf_starve <= bus.perf_starve + 32'd1;
        end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a reference memory model
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;
    localparam int AW = 8;
    localparam int SM = 4;
    typedef struct {bit is_d; logic [31:0] data; int due;} exp_t;
    typedef struct {logic [3:0] we; logic [31:0] addr; logic [31:0] wdata;} dreq_t;
    logic clk = 0, rst = 0;
    int total = 0, bad = 0, cyc = 0, starve = 0, pc = 0, ps = 0;
    logic [31:0] ram [256];
    logic [31:0] ref_mem [256];
    logic [31:0] iq [$];
    dreq_t dq [$];
    exp_t sq [$];
    exp_t e;
    dreq_t dr;
    bit i_took = 0, d_took = 0, eg_i, eg_d;
    always #5 clk = ~clk;
    mem_port_arbiter_if #(.AW(AW)) bus ();
    mem_port_arbiter #(.AW(AW), .STARVE_MAX(SM)) dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic chk(string n, logic [31:0] a, logic [31:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", n, a, x, cyc);
        end
    endtask
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.ram_en) begin
        bus.ram_rdata <= ram[bus.ram_addr];
        for (int b = 0; b < 4; b++) if (bus.ram_we[b]) ram[bus.ram_addr][8*b +: 8] = bus.ram_wdata[8*b +: 8];
    end
    // drivers: hold each request until the cycle it is granted, then present the next
    always @(posedge clk) begin
        #1;
        if (!bus.i_req || i_took) begin
            bus.i_req = iq.size() != 0;
            if (bus.i_req) bus.i_addr = iq.pop_front();
        end
        if (!bus.d_req || d_took) begin
            bus.d_req = dq.size() != 0;
            if (bus.d_req) begin
                dr = dq.pop_front();
                bus.d_we = dr.we; bus.d_addr = dr.addr; bus.d_wdata = dr.wdata;
            end
        end
    end
    // reference model: arbitration from the priority/starvation rules, data from ref_mem
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_i_gnt", 32'(bus.i_gnt), 0);
            chk("rst_d_gnt", 32'(bus.d_gnt), 0);
            chk("rst_ram_en", 32'(bus.ram_en), 0);
            starve = 0; pc = 0; ps = 0;
        end else begin
            eg_d = bus.d_req && !(bus.i_req && starve >= SM);
            eg_i = bus.i_req && !eg_d;
            chk("i_gnt", 32'(bus.i_gnt), 32'(eg_i));
            chk("d_gnt", 32'(bus.d_gnt), 32'(eg_d));
            chk("stall_i", 32'(bus.stall_i), 32'(bus.i_req && !eg_i));
            chk("stall_d", 32'(bus.stall_d), 32'(bus.d_req && !eg_d));
            chk("ram_en", 32'(bus.ram_en), 32'(eg_i || eg_d));
            chk("ram_addr", 32'(bus.ram_addr), eg_d ? 32'(bus.d_addr[9:2]) : eg_i ? 32'(bus.i_addr[9:2]) : 0);
            chk("ram_we", 32'(bus.ram_we), eg_d ? 32'(bus.d_we) : 0);
            chk("ram_wdata", bus.ram_wdata, eg_d ? bus.d_wdata : 0);
            if (eg_i) sq.push_back('{0, ref_mem[bus.i_addr[9:2]], cyc + 1});
            if (eg_d) begin
                sq.push_back('{1, bus.d_we != 0 ? 32'h0 : ref_mem[bus.d_addr[9:2]], cyc + 1});
                for (int b = 0; b < 4; b++) if (bus.d_we[b]) ref_mem[bus.d_addr[9:2]][8*b +: 8] = bus.d_wdata[8*b +: 8];
            end
            pc += int'(bus.i_req && bus.d_req);
            ps += int'(eg_i && bus.d_req);
            starve = (bus.i_req && !eg_i) ? (starve < SM ? starve + 1 : SM) : 0;
        end
        i_took = bus.i_gnt; d_took = bus.d_gnt;
    end
    // monitor: every response beat must match the oldest expectation, due exactly one cycle after grant
    always @(negedge clk) begin
        chk("one_rvalid", 32'(bus.i_rvalid && bus.d_rvalid), 0);
        if (!rst) begin
            chk("rst_i_rvalid", 32'(bus.i_rvalid), 0);
            chk("rst_d_rvalid", 32'(bus.d_rvalid), 0);
            sq.delete();
        end else if (bus.i_rvalid || bus.d_rvalid) begin
            if (sq.size() == 0) chk("spurious_rvalid", 1, 0);
            else begin
                e = sq.pop_front();
                chk("resp_due", cyc, e.due);
                chk("resp_port", 32'(bus.d_rvalid), 32'(e.is_d));
                chk("resp_data", bus.d_rvalid ? bus.d_rdata : bus.i_rdata, e.data);
                chk("idle_rdata", bus.d_rvalid ? bus.i_rdata : bus.d_rdata, 0);
            end
        end else begin
            chk("no_rv_rdata", bus.i_rdata | bus.d_rdata, 0);
            if (sq.size() != 0 && sq[0].due <= cyc) begin
                chk("missing_resp", 0, 1);
                void'(sq.pop_front());
            end
        end
    end
    task automatic drain();
        int n = 0;
        while ((iq.size() != 0 || dq.size() != 0 || bus.i_req || bus.d_req || sq.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n >= 300), 0);
        repeat (2) @(posedge clk);
    endtask
    initial begin
        int n;
        for (int i = 0; i < 256; i++) ram[i] = $urandom;
        ram[0] = 32'h20080005;
        ref_mem = ram;
        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.ram_rdata = 0;
        iq.push_back(32'h100);
        dq.push_back('{4'h0, 32'h200, 32'h0});
        repeat (3) @(posedge clk);
        #2 rst = 1;
        drain();
        foreach (iq[k]) iq.delete(k);
        iq.push_back(32'h0); iq.push_back(32'h4); iq.push_back(32'h8);
        drain();
        dq.push_back('{4'hF, 32'h54, 32'h7});
        dq.push_back('{4'h0, 32'h54, 32'h0});
        drain();
        dq.push_back('{4'h0, 32'h10, 32'h0});
        iq.push_back(32'h20);
        drain();
        iq.push_back(32'h30);
        for (int k = 0; k < 6; k++) dq.push_back('{4'h0, 32'h100 + 4 * k, 32'h0});
        drain();
        iq.push_back(32'h44);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.i_gnt && n < 50);
        chk("mid_rst_grant_seen", 32'(bus.i_gnt), 1);
        #1 rst = 0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1;
        drain();
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            if (iq.size() < 2 && $urandom_range(0, 2) != 0) iq.push_back($urandom);
            if (dq.size() < 2 && $urandom_range(0, 2) != 0)
                dq.push_back('{$urandom_range(0, 2) == 0 ? 4'h0 : 4'($urandom), $urandom, $urandom});
        end
        drain();
`ifdef MEM_ARB_PERF_EN
        chk("perf_conflict", bus.perf_conflict, pc);
        chk("perf_starve", bus.perf_starve, ps);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM (1-cycle read latency, byte write enables) between the instruction-fetch port and the data-memory port of the 5-stage MIPS pipeline.
- The pipeline runs with a unified instruction/data memory instead of separate inst_ram/data_ram.
- Grants one requester per cycle, routes read data back one cycle later, and drives the fetch/memory stall signals consumed by the hazard unit.
- Fixed data-over-instruction priority with a starvation guard for fetch.

Parameters:
- AW, 8: RAM word-address width; request addresses are byte addresses, RAM index = addr[AW+1:2].
- STARVE_MAX, 4: consecutive denied fetch cycles after which fetch wins the next conflict.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- i_req  in  1  fetch request; held until granted.
- i_addr  in  32  fetch byte address (pc).
- i_gnt  out  1  fetch granted this cycle (combinational).
- i_rvalid  out  1  fetch data valid (cycle after grant).
- i_rdata  out  32  fetch data; 0 when i_rvalid=0.
- d_req  in  1  data request (load or store).
- d_we  in  4  byte write enables; 0 means read.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_gnt  out  1  data granted this cycle (combinational).
- d_rvalid  out  1  data response valid (load data or store complete).
- d_rdata  out  32  load data; 0 when d_rvalid=0 or the access was a store.
- ram_en  out  1  RAM enable.
- ram_we  out  4  RAM byte write enables.
- ram_addr  out  AW  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid the cycle after ram_en.
- stall_i  out  1  i_req & ~i_gnt.
- stall_d  out  1  d_req & ~d_gnt.

Behaviour:
- Requester rule:
  - req/addr/we/wdata stay stable while req=1 and gnt=0.
  - In the gnt cycle the request is consumed; the next cycle may present a new request.
  - Throughput is 1 grant/cycle in total.
- Grant logic (combinational, same cycle as req):
  - Only one requester: it is granted.
  - Both requesting: d wins unless starve_cnt == STARVE_MAX, then i wins.
  - Neither requesting: no grant.
  - Any grant drives ram_en=1; ram_addr/ram_we/ram_wdata come from the granted port; ram_we=0 for fetch.
  - No grant drives ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
- Response register resp_sel ∈ {NONE, I, D}:
  - Loaded every cycle with the grant just issued.
  - resp_sel=I: i_rvalid=1, i_rdata=ram_rdata.
  - resp_sel=D: d_rvalid=1, d_rdata=ram_rdata for reads and 0 for stores (registered resp_wr flag).
  - Latency from grant to rvalid is exactly 1 cycle. Back-to-back grants to either port are legal.
- Starvation counter (0..STARVE_MAX):
  - Increments when i_req & d_req & d_gnt.
  - Clears when i_gnt, or when i_req=0.
  - Saturates at STARVE_MAX.
- Reset (rst=0 at a rising edge):
  - resp_sel=NONE, resp_wr=0, starve_cnt=0.
  - Next cycle: i_rvalid=d_rvalid=0 and rdata=0.
  - While rst=0: gnt outputs=0 and ram_en=0, regardless of req.
  - A response pending when reset is asserted is discarded.
- Address wrap: upper address bits above AW+1 are ignored; no error.

Optional Feature:
MEM_ARB_PERF_EN:
- Defined: adds outputs perf_conflict[31:0] (cycles with i_req & d_req) and perf_starve[31:0] (grants forced by the starvation guard).
  - Both are wrapping counters, cleared on reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - resp_sel_t enum {RESP_NONE, RESP_I, RESP_D};
  - data width constant DW=32;
  - byte-enable width BEW=4.
- One sub-module, mem_arb_starve_ctr: the saturating counter with inc/clr/at_max; parameterised by STARVE_MAX.

Test Plan:
- Reset then idle: rst=0 for 2 cycles with i_req=d_req=1 -> gnt=0, ram_en=0, rvalid=0. After release, first cycle: d_gnt=1, i_gnt=0, stall_i=1.
- Fetch only: i_req=1, i_addr=0x0,0x4,0x8 on consecutive cycles; RAM holds 0x20080005 at word 0 -> i_gnt=1 every cycle, ram_addr=0,1,2. Cycle after first grant: i_rvalid=1, i_rdata=0x20080005.
- Store then load: d_req, d_we=4'hF, d_addr=0x54, d_wdata=0x00000007; next cycle d_req, d_we=0, d_addr=0x54 -> ram_we=F then 0 at ram_addr=0x15. Store response: d_rvalid=1, d_rdata=0. Load response: d_rvalid=1, d_rdata=0x7.
- Conflict: i_req and d_req both high for one cycle, then only i_req -> d granted first, stall_i=1. i granted next cycle; i_rvalid follows one cycle later with correct word.
- Starvation: i_req held, d_req held high with new addr each grant, STARVE_MAX=4 -> d granted 4 cycles, i granted on 5th, stall_d=1 that cycle, counter clears.
- Reset mid-response: grant a fetch, assert rst=0 the next edge -> i_rvalid=0 the following cycle, no response ever delivered for that grant.
